mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch path (read-only) and the load/store path (read/write).
- Used when the core moves from separate instruction/data memories to one memory.
- Sequences each transaction with a request/acknowledge handshake.
- Data has priority, with a bounded-starvation guarantee for fetch, and a timeout with an error response.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between a read-only fetch port and a read/write data port.
// Data wins in IDLE unless fetch has waited through MAX_DATA_RUN data grants; stalled transfers time out.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_RUN   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err_sticky
);

    localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_DATA_RUN);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [RUN_W-1:0]  data_run_q, data_run_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              err_sticky_q, err_sticky_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic in_busy;
    logic tmo_hit;
    logic done;
    logic grant_i;
    logic grant_d;

    // Completion is combinational on mem_ack; a timeout only fires when mem_ack is absent.
    always_comb begin
        in_busy = (state_q != IDLE);
        tmo_hit = in_busy && !mem_ack && (tmo_cnt_q == TMO_LAST);
        done    = in_busy && (mem_ack || tmo_hit);

        i_ack   = (state_q == BUSY_I) && done;
        i_err   = (state_q == BUSY_I) && tmo_hit;
        i_rdata = ((state_q == BUSY_I) && mem_ack) ? mem_rdata : '0;
        d_ack   = (state_q == BUSY_D) && done;
        d_err   = (state_q == BUSY_D) && tmo_hit;
        d_rdata = ((state_q == BUSY_D) && mem_ack) ? mem_rdata : '0;
    end

    // Priority/run rule only in IDLE; a finishing port always hands off to the other one.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (d_req && (!i_req || (data_run_q < RUN_MAX))) begin
                    grant_d = 1'b1;
                end else if (i_req) begin
                    grant_i = 1'b1;
                end
            end
            BUSY_I:  grant_d = done && d_req;
            BUSY_D:  grant_i = done && i_req;
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        err_sticky_d = err_sticky_q | tmo_hit;
        tmo_cnt_d    = in_busy ? (tmo_cnt_q + TMO_W'(1)) : '0;

        if (grant_d) begin
            state_d     = BUSY_D;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            tmo_cnt_d   = '0;
        end else if (grant_i) begin
            state_d    = BUSY_I;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = i_addr;
            tmo_cnt_d  = '0;
        end else if (done) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            tmo_cnt_d = '0;
        end

        if (!i_req || grant_i) begin
            data_run_d = '0;
        end else if (grant_d && (data_run_q != RUN_MAX)) begin
            data_run_d = data_run_q + RUN_W'(1);
        end else begin
            data_run_d = data_run_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            data_run_q   <= '0;
            tmo_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            data_run_q   <= data_run_d;
            tmo_cnt_q    <= tmo_cnt_d;
            err_sticky_q <= err_sticky_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = (state_q != IDLE);
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner-case sequences and random traffic,
// all outputs also checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int MAXRUN = 4;
    localparam int TMO    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          i_req, i_ack, i_err;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_ack, d_err;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy, err_sticky;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_DATA_RUN(MAXRUN), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .err_sticky(err_sticky)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: who owns the memory, how long the transfer has run, fetch wait count.
    int          m_owner;   // 0 none, 1 fetch, 2 data
    int          m_age;     // completed BUSY cycles of the current transfer
    int          m_run;
    bit          m_err, m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    bit          e_tmo, e_done, e_i_ack, e_d_ack;

    task automatic model_check();
        logic [31:0] exp_rd;
        e_tmo   = (m_owner != 0) && !mem_ack && (m_age == TMO - 1);
        e_done  = (m_owner != 0) && (mem_ack || e_tmo);
        e_i_ack = (m_owner == 1) && e_done;
        e_d_ack = (m_owner == 2) && e_done;
        chk("i_ack", i_ack, e_i_ack);
        chk("i_err", i_err, (m_owner == 1) && e_tmo);
        exp_rd = ((m_owner == 1) && mem_ack) ? mem_rdata : 32'h0;
        chk("i_rdata", i_rdata, exp_rd);
        chk("d_ack", d_ack, e_d_ack);
        chk("d_err", d_err, (m_owner == 2) && e_tmo);
        if (!((m_owner == 2) && m_we && mem_ack)) begin
            exp_rd = ((m_owner == 2) && mem_ack) ? mem_rdata : 32'h0;
            chk("d_rdata", d_rdata, exp_rd);
        end
        chk("mem_req", mem_req, m_req);
        chk("busy", busy, m_owner != 0);
        chk("err_sticky", err_sticky, m_err);
        if (m_req) begin
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    task automatic model_update();
        int win;
        if (rst) begin
            m_owner = 0; m_age = 0; m_run = 0; m_err = 0;
            m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
            return;
        end
        win = 0;
        if (m_owner == 0) begin
            if (d_req && (!i_req || m_run < MAXRUN)) win = 2;
            else if (i_req) win = 1;
        end else if (e_done) begin
            if (e_tmo) m_err = 1;
            if (m_owner == 1) win = d_req ? 2 : 0;
            else              win = i_req ? 1 : 0;
            if (win == 0) begin
                m_owner = 0;
                m_req   = 0;
            end
        end else begin
            m_age++;
        end
        if (!i_req || win == 1) m_run = 0;
        else if (win == 2 && m_run < MAXRUN) m_run++;
        if (win != 0) begin
            m_owner = win;
            m_age   = 0;
            m_req   = 1;
            m_we    = (win == 2) ? d_we : 1'b0;
            m_addr  = (win == 2) ? d_addr : i_addr;
            if (win == 2) m_wdata = d_wdata;
        end
    endtask

    task automatic finish_cycle();
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        finish_cycle();
    endtask

    typedef struct {
        bit          rst, i_req;
        logic [31:0] i_addr;
        bit          d_req, d_we;
        logic [31:0] d_addr, d_wdata;
        bit          mem_ack;
        logic [31:0] mem_rdata;
        bit          x_i_ack;
        logic [31:0] x_i_rdata;
        bit          x_d_ack, x_mem_req, x_mem_we;
        logic [31:0] x_mem_addr;
        bit          x_busy;
    } vec_t;

    vec_t tbl[11];
    bit   slow;

    initial begin
        // rst i_req i_addr     d_req we d_addr     d_wdata    ack rdata          | i_ack i_rdata       d_ack mreq mwe maddr      busy
        tbl[0]  = '{0, 0, 32'h0,  0, 0, 32'h0,   32'h0,    0, 32'h0,          0, 32'h0,          0, 0, 0, 32'h0,   0};
        tbl[1]  = '{0, 1, 32'h10, 0, 0, 32'h0,   32'h0,    0, 32'h0,          0, 32'h0,          0, 0, 0, 32'h0,   0};
        tbl[2]  = '{0, 1, 32'h10, 0, 0, 32'h0,   32'h0,    0, 32'h0,          0, 32'h0,          0, 1, 0, 32'h10,  1};
        tbl[3]  = '{0, 1, 32'h10, 0, 0, 32'h0,   32'h0,    1, 32'hDEADBEEF,   1, 32'hDEADBEEF,   0, 1, 0, 32'h10,  1};
        tbl[4]  = '{0, 0, 32'h10, 0, 0, 32'h0,   32'h0,    1, 32'h55,         0, 32'h0,          0, 0, 0, 32'h0,   0};
        tbl[5]  = '{0, 1, 32'h30, 1, 1, 32'h200, 32'h1234, 0, 32'h0,          0, 32'h0,          0, 0, 0, 32'h0,   0};
        tbl[6]  = '{0, 1, 32'h30, 1, 1, 32'h200, 32'h1234, 0, 32'h0,          0, 32'h0,          0, 1, 1, 32'h200, 1};
        tbl[7]  = '{0, 1, 32'h30, 1, 1, 32'h200, 32'h1234, 1, 32'h0,          0, 32'h0,          1, 1, 1, 32'h200, 1};
        tbl[8]  = '{0, 1, 32'h30, 0, 0, 32'h200, 32'h1234, 0, 32'h0,          0, 32'h0,          0, 1, 0, 32'h30,  1};
        tbl[9]  = '{0, 1, 32'h30, 0, 0, 32'h0,   32'h0,    1, 32'hCAFE0001,   1, 32'hCAFE0001,   0, 1, 0, 32'h30,  1};
        tbl[10] = '{0, 0, 32'h0,  0, 0, 32'h0,   32'h0,    0, 32'h0,          0, 32'h0,          0, 0, 0, 32'h0,   0};

        // Clock/reset
        rst = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_ack = 0; mem_rdata = 0; slow = 0;
        repeat (2) begin
            @(posedge clk);
            model_update();
        end
        #1;
        rst = 0;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_sticky", err_sticky, 0);

        // Directed vector table: single fetch, spurious ack, simultaneous requests with handoff
        for (int k = 0; k < 11; k++) begin
            rst = tbl[k].rst; i_req = tbl[k].i_req; i_addr = tbl[k].i_addr;
            d_req = tbl[k].d_req; d_we = tbl[k].d_we; d_addr = tbl[k].d_addr;
            d_wdata = tbl[k].d_wdata; mem_ack = tbl[k].mem_ack; mem_rdata = tbl[k].mem_rdata;
            @(negedge clk);
            chk($sformatf("tbl%0d_i_ack", k), i_ack, tbl[k].x_i_ack);
            chk($sformatf("tbl%0d_i_rdata", k), i_rdata, tbl[k].x_i_rdata);
            chk($sformatf("tbl%0d_d_ack", k), d_ack, tbl[k].x_d_ack);
            chk($sformatf("tbl%0d_mem_req", k), mem_req, tbl[k].x_mem_req);
            chk($sformatf("tbl%0d_busy", k), busy, tbl[k].x_busy);
            if (tbl[k].x_mem_req) begin
                chk($sformatf("tbl%0d_mem_we", k), mem_we, tbl[k].x_mem_we);
                chk($sformatf("tbl%0d_mem_addr", k), mem_addr, tbl[k].x_mem_addr);
            end
            if (tbl[k].x_mem_req && tbl[k].x_mem_we)
                chk($sformatf("tbl%0d_mem_wdata", k), mem_wdata, tbl[k].d_wdata);
            finish_cycle();
        end

        // Both ports held busy, memory acks in the first BUSY cycle: grants alternate data/fetch
        i_req = 1; i_addr = 32'h400; d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h99;
        mem_ack = 0;
        for (int k = 0; k < 10; k++) begin
            mem_ack = m_req; mem_rdata = $urandom;
            tick();
            chk("alt_mem_req", mem_req, 1);
            chk("alt_mem_we", mem_we, (k % 2) == 0);
        end
        d_req = 0; mem_ack = 1;
        tick();
        chk("alt_end_idle", busy, 0);
        i_req = 0; mem_ack = 0;
        tick();

        // Timeout on a data read: error completion in the 16th BUSY cycle, sticky flag survives
        d_req = 1; d_we = 0; d_addr = 32'h500; mem_ack = 0;
        tick();
        for (int k = 0; k < TMO - 1; k++) tick();
        @(negedge clk);
        chk("tmo_d_ack", d_ack, 1);
        chk("tmo_d_err", d_err, 1);
        chk("tmo_d_rdata", d_rdata, 0);
        finish_cycle();
        chk("tmo_sticky", err_sticky, 1);
        d_req = 0; i_req = 1; i_addr = 32'h44;
        tick();
        mem_ack = 1; mem_rdata = 32'h1111;
        tick();
        i_req = 0; mem_ack = 0;
        tick();
        chk("tmo_sticky_kept", err_sticky, 1);

        // Reset in BUSY_D drops the transfer; a late mem_ack is ignored
        d_req = 1; d_we = 0; d_addr = 32'h600;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0; d_req = 0;
        chk("rstmid_mem_req", mem_req, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_sticky", err_sticky, 0);
        tick();
        mem_ack = 1; mem_rdata = 32'h7777;
        @(negedge clk);
        chk("rstmid_late_ack", d_ack, 0);
        finish_cycle();
        mem_ack = 0;

        // Latching: requester address moves after grant; then a spurious ack in IDLE
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hAA;
        tick();
        d_addr = 32'h80;
        tick();
        chk("latch_addr", mem_addr, 32'h40);
        mem_ack = 1;
        tick();
        d_req = 0; mem_ack = 1; mem_rdata = 32'h5A5A;
        @(negedge clk);
        chk("spur_i_ack", i_ack, 0);
        chk("spur_d_ack", d_ack, 0);
        finish_cycle();
        mem_ack = 0;

        // Random traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) slow = ~slow;
            if (!i_req || e_i_ack) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
                i_addr = $urandom;
            end
            if (!d_req || e_d_ack) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            if (m_req) mem_ack = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            else       mem_ack = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
